// File: rtl/uart_tx_frame.sv
// uart_tx_frame: 8N1 UART serialiser with built-in baud divider and bit counter.
// Accepts one byte per tx_valid/tx_ready handshake. txd idles high and is always
// driven straight from a register.
// Optional even-parity bit between the data bits and the stop bit when the
// macro UART_TX_PARITY_EN is defined; default build is plain 8N1.
module uart_tx_frame #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned BAUD_DIV = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       tx_busy,
    output logic       frame_done
);

    localparam int unsigned CNT_W   = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned LAST_BIT = 7;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BAUD_DIV - 2);

    // Reject divisors that cannot form a bit period.
    generate
        if (BAUD_DIV < 2) begin : g_bad_baud_div
            $error("uart_tx_frame: BAUD_DIV must be 2 or more");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_txd;
    logic             r_tx_ready;
    logic             r_tx_busy;
    logic             r_frame_done;
`ifdef UART_TX_PARITY_EN
    logic             r_parity;
`endif

    logic w_last;

    // Last cycle of the current bit period.
    assign w_last = (r_cnt == CNT_LAST);

    // Frame sequencer: state, baud counter, bit index, shift register, outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_txd        <= 1'b1;
            r_tx_ready   <= 1'b1;
            r_tx_busy    <= 1'b0;
            r_frame_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            r_cnt        <= w_last ? '0 : r_cnt + CNT_W'(1);

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (tx_valid && r_tx_ready) begin
                        r_shift    <= tx_data;
`ifdef UART_TX_PARITY_EN
                        r_parity   <= ^tx_data;
`endif
                        r_state    <= S_START;
                        r_txd      <= 1'b0;
                        r_tx_ready <= 1'b0;
                        r_tx_busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (w_last) begin
                        r_state <= S_DATA;
                        r_txd   <= r_shift[0];
                    end
                end

                S_DATA: begin
                    if (w_last) begin
                        if (r_bit == 3'(LAST_BIT)) begin
                            r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
                            r_state <= S_PARITY;
                            r_txd   <= r_parity;
`else
                            r_state <= S_STOP;
                            r_txd   <= 1'b1;
`endif
                        end else begin
                            r_bit   <= r_bit + 3'(1);
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_txd   <= r_shift[1];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_last) begin
                        r_state <= S_STOP;
                        r_txd   <= 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    // Pulse lands on the final stop-bit cycle.
                    if (r_cnt == CNT_PRE) begin
                        r_frame_done <= 1'b1;
                    end
                    if (w_last) begin
                        r_state    <= S_IDLE;
                        r_tx_ready <= 1'b1;
                        r_tx_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_cnt      <= '0;
                    r_txd      <= 1'b1;
                    r_tx_ready <= 1'b1;
                    r_tx_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign txd        = r_txd;
    assign tx_ready   = r_tx_ready;
    assign tx_busy    = r_tx_busy;
    assign frame_done = r_frame_done;

endmodule
